line_to_word_mem_bridge: RTL and testbench

//  Sits between the L2 cache-hierarchy memory side (one cache line per message) and
//  the word-wide main memory. Splits line reads/writebacks into 2^OFFSET_BITS

---
 rtl/line_to_word_mem_bridge.sv | 127 ++++++++++++
 tb/tb_line_to_word_mem_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_to_word_mem_bridge.sv
// Bridges one-line cache requests to a word-wide main memory: a line read or writeback
// becomes 2^OFFSET_BITS serial word transactions, and one line response is returned.
module line_to_word_mem_bridge #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int OFFSET_BITS   = 2,
    parameter int MSG_BITS      = 4,
    localparam int LINE_W       = DATA_WIDTH << OFFSET_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      cache2bridge_msg,
    input  logic [ADDRESS_WIDTH-1:0] cache2bridge_address,
    input  logic [LINE_W-1:0]        cache2bridge_data,
    output logic [MSG_BITS-1:0]      bridge2cache_msg,
    output logic [ADDRESS_WIDTH-1:0] bridge2cache_address,
    output logic [LINE_W-1:0]        bridge2cache_data,
    output logic [MSG_BITS-1:0]      bridge2mem_msg,
    output logic [ADDRESS_WIDTH-1:0] bridge2mem_address,
    output logic [DATA_WIDTH-1:0]    bridge2mem_data,
    input  logic [MSG_BITS-1:0]      mem2bridge_msg,
    input  logic [ADDRESS_WIDTH-1:0] mem2bridge_address,
    input  logic [DATA_WIDTH-1:0]    mem2bridge_data,
    output logic                     busy
);

    localparam logic [MSG_BITS-1:0]    NO_REQ   = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0]    R_REQ    = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0]    WB_REQ   = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0]    MEM_RESP = MSG_BITS'(3);
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = {OFFSET_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        RD_WORD,
        WR_WORD,
        RESPOND
    } state_t;

    state_t                   state;
    logic [OFFSET_BITS-1:0]   word_cnt;
    logic [ADDRESS_WIDTH-1:0] base_addr;
    logic [LINE_W-1:0]        line_buf;

    logic mem_hit;
    logic line_match;
    logic unused_offset_bits;

    // The line offset of a cache address carries no meaning; only the line is kept.
    assign unused_offset_bits = ^cache2bridge_address[OFFSET_BITS-1:0];

    // A response only counts while a word request is actually on the bus.
    assign mem_hit = (bridge2mem_msg != NO_REQ) &&
                     (mem2bridge_msg == MEM_RESP) &&
                     (mem2bridge_address == bridge2mem_address);

    assign line_match = cache2bridge_address[ADDRESS_WIDTH-1:OFFSET_BITS] ==
                        base_addr[ADDRESS_WIDTH-1:OFFSET_BITS];

    assign busy = (state != IDLE);

    // NOTE: all state and outputs live in one clocked block with non-blocking
    // assignments, so every read of a register in here sees its pre-edge value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state                <= IDLE;
            word_cnt             <= '0;
            base_addr            <= '0;
            line_buf             <= '0;
            bridge2cache_msg     <= NO_REQ;
            bridge2cache_address <= '0;
            bridge2cache_data    <= '0;
            bridge2mem_msg       <= NO_REQ;
            bridge2mem_address   <= '0;
            bridge2mem_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache2bridge_msg == R_REQ || cache2bridge_msg == WB_REQ) begin
                        base_addr <= {cache2bridge_address[ADDRESS_WIDTH-1:OFFSET_BITS],
                                      {OFFSET_BITS{1'b0}}};
                        line_buf  <= cache2bridge_data;
                        word_cnt  <= '0;
                        state     <= (cache2bridge_msg == R_REQ) ? RD_WORD : WR_WORD;
                    end
                end

                RD_WORD, WR_WORD: begin
                    if (bridge2mem_msg == NO_REQ) begin
                        // Bus idle for one cycle: present the current word.
                        bridge2mem_msg     <= (state == RD_WORD) ? R_REQ : WB_REQ;
                        bridge2mem_address <= {base_addr[ADDRESS_WIDTH-1:OFFSET_BITS], word_cnt};
                        bridge2mem_data    <= (state == WR_WORD) ?
                            line_buf[int'(word_cnt) * DATA_WIDTH +: DATA_WIDTH] : '0;
                    end else if (mem_hit) begin
                        bridge2mem_msg <= NO_REQ;
                        if (state == RD_WORD)
                            line_buf[int'(word_cnt) * DATA_WIDTH +: DATA_WIDTH] <= mem2bridge_data;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= RESPOND;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end

                RESPOND: begin
                    if (bridge2cache_msg != MEM_RESP) begin
                        bridge2cache_msg     <= MEM_RESP;
                        bridge2cache_address <= base_addr;
                        bridge2cache_data    <= line_buf;
                    end else if (cache2bridge_msg == NO_REQ || !line_match) begin
                        // The cache has moved on; any new request waits for IDLE.
                        bridge2cache_msg     <= NO_REQ;
                        bridge2cache_address <= '0;
                        bridge2cache_data    <= '0;
                        state                <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_to_word_mem_bridge.sv
// Directed plus randomized bench for line_to_word_mem_bridge against a line-level
// reference: expected word order, addresses, data and response latency from plain arithmetic.
module tb_line_to_word_mem_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int OB = 2;
    localparam int MB = 4;
    localparam int N_WORDS = 1 << OB;
    localparam int LW = DW * N_WORDS;

    localparam logic [MB-1:0] NO_REQ   = 4'd0;
    localparam logic [MB-1:0] R_REQ    = 4'd1;
    localparam logic [MB-1:0] WB_REQ   = 4'd2;
    localparam logic [MB-1:0] MEM_RESP = 4'd3;

    logic          clock = 1'b0;
    logic          reset;
    logic [MB-1:0] cache2bridge_msg;
    logic [AW-1:0] cache2bridge_address;
    logic [LW-1:0] cache2bridge_data;
    logic [MB-1:0] bridge2cache_msg;
    logic [AW-1:0] bridge2cache_address;
    logic [LW-1:0] bridge2cache_data;
    logic [MB-1:0] bridge2mem_msg;
    logic [AW-1:0] bridge2mem_address;
    logic [DW-1:0] bridge2mem_data;
    logic [MB-1:0] mem2bridge_msg     = '0;
    logic [AW-1:0] mem2bridge_address = '0;
    logic [DW-1:0] mem2bridge_data    = '0;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory model state and the log of word requests it has seen
    logic [DW-1:0] mem_array [logic [AW-1:0]];
    logic [MB-1:0] log_msg  [$];
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    int            mem_lat   = 1;
    int            req_age   = 0;
    bit            stale_once = 1'b0;

    logic [AW-1:0] last_resp_addr;
    logic [LW-1:0] last_resp_data;

    line_to_word_mem_bridge dut (
        .clock                (clock),
        .reset                (reset),
        .cache2bridge_msg     (cache2bridge_msg),
        .cache2bridge_address (cache2bridge_address),
        .cache2bridge_data    (cache2bridge_data),
        .bridge2cache_msg     (bridge2cache_msg),
        .bridge2cache_address (bridge2cache_address),
        .bridge2cache_data    (bridge2cache_data),
        .bridge2mem_msg       (bridge2mem_msg),
        .bridge2mem_address   (bridge2mem_address),
        .bridge2mem_data      (bridge2mem_data),
        .mem2bridge_msg       (mem2bridge_msg),
        .mem2bridge_address   (mem2bridge_address),
        .mem2bridge_data      (mem2bridge_data),
        .busy                 (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (mem_array.exists(a))
            return mem_array[a];
        return a * 32'h9E37_79B9 + 32'h0000_1234;
    endfunction

    // Word memory: answers so the bridge samples MEM_RESP at the mem_lat-th edge
    // after a request appears; optionally slips in one response for a foreign address.
    always @(negedge clock) begin
        if (bridge2mem_msg == R_REQ || bridge2mem_msg == WB_REQ) begin
            if (req_age == 0) begin
                log_msg.push_back(bridge2mem_msg);
                log_addr.push_back(bridge2mem_address);
                log_data.push_back(bridge2mem_data);
                if (bridge2mem_msg == WB_REQ)
                    mem_array[bridge2mem_address] = bridge2mem_data;
            end
            req_age = req_age + 1;
            if (req_age >= mem_lat) begin
                mem2bridge_msg     = MEM_RESP;
                mem2bridge_address = bridge2mem_address;
                mem2bridge_data    = (bridge2mem_msg == R_REQ) ? mem_word(bridge2mem_address)
                                                               : 32'h0BAD_0BAD;
            end else if (stale_once) begin
                stale_once         = 1'b0;
                mem2bridge_msg     = MEM_RESP;
                mem2bridge_address = 32'h0000_0999;
                mem2bridge_data    = $urandom;
            end else begin
                mem2bridge_msg     = NO_REQ;
                mem2bridge_address = '0;
                mem2bridge_data    = '0;
            end
        end else begin
            req_age            = 0;
            mem2bridge_msg     = NO_REQ;
            mem2bridge_address = '0;
            mem2bridge_data    = '0;
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [MB-1:0] msg, input logic [AW-1:0] addr,
                             input logic [LW-1:0] data);
        @(negedge clock);
        cache2bridge_msg     = msg;
        cache2bridge_address = addr;
        cache2bridge_data    = data;
    endtask

    // Runs one line transfer whose request is sampled at the next rising edge.
    task automatic finish_txn(input logic [MB-1:0] msg, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input int lat, input int hold,
                              input bit chain, input logic [AW-1:0] chain_addr);
        logic [AW-1:0] base;
        logic [LW-1:0] exp_line;
        logic [MB-1:0] got_msg;
        logic [AW-1:0] got_addr;
        logic [DW-1:0] got_data;
        int            lat_total;

        base = addr - (addr % N_WORDS);
        for (int i = 0; i < N_WORDS; i++)
            exp_line[i*DW +: DW] = (msg == R_REQ) ? mem_word(base + i) : wdata[i*DW +: DW];
        log_msg.delete();
        log_addr.delete();
        log_data.delete();
        mem_lat   = lat;
        lat_total = 1 + N_WORDS * (lat + 1) + 1;

        @(posedge clock);
        // The latched copy must be used; scramble what the cache presents.
        #1 cache2bridge_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (lat_total - 2) @(posedge clock);
        @(negedge clock);
        check("resp_not_early", bridge2cache_msg, NO_REQ);
        check("busy_in_transfer", busy, 1'b1);
        @(negedge clock);
        check("resp_msg", bridge2cache_msg, MEM_RESP);
        check("resp_addr", bridge2cache_address, base);
        check("resp_data", bridge2cache_data, exp_line);
        last_resp_addr = bridge2cache_address;
        last_resp_data = bridge2cache_data;

        check("word_count", log_addr.size(), N_WORDS);
        for (int i = 0; i < N_WORDS; i++) begin
            got_msg  = 'x;
            got_addr = 'x;
            got_data = 'x;
            if (i < log_addr.size()) begin
                got_msg  = log_msg[i];
                got_addr = log_addr[i];
                got_data = log_data[i];
            end
            check("word_msg", got_msg, msg);
            check("word_addr", got_addr, base + i);
            if (msg == WB_REQ)
                check("word_wdata", got_data, wdata[i*DW +: DW]);
        end

        repeat (hold) begin
            @(negedge clock);
            check("resp_held", bridge2cache_msg, MEM_RESP);
            check("no_reissue", bridge2mem_msg, NO_REQ);
        end

        if (chain) begin
            cache2bridge_msg     = R_REQ;
            cache2bridge_address = chain_addr;
        end else begin
            cache2bridge_msg = NO_REQ;
        end
        @(negedge clock);
        check("exit_msg", bridge2cache_msg, NO_REQ);
        check("exit_busy", busy, 1'b0);
        check("exit_mem_idle", bridge2mem_msg, NO_REQ);
    endtask

    initial begin
        logic [MB-1:0] r_msg;
        logic [AW-1:0] r_addr;
        logic [LW-1:0] r_data;
        logic [LW-1:0] wb_line;

        reset                = 1'b0;
        cache2bridge_msg     = NO_REQ;
        cache2bridge_address = '0;
        cache2bridge_data    = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_cache_msg", bridge2cache_msg, NO_REQ);
        check("rst_cache_addr", bridge2cache_address, '0);
        check("rst_cache_data", bridge2cache_data, '0);
        check("rst_mem_msg", bridge2mem_msg, NO_REQ);
        check("rst_mem_addr", bridge2mem_address, '0);
        check("rst_mem_data", bridge2mem_data, '0);
        reset = 1'b1;

        for (int i = 0; i < N_WORDS; i++)
            mem_array[32'h104 + i] = 32'hA0 + i;

        // Reset while word 2 of a read is outstanding
        mem_lat = 1;
        start_req(R_REQ, 32'h104, '0);
        @(posedge clock);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("pre_reset_word2_addr", bridge2mem_address, 32'h106);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_mem_msg", bridge2mem_msg, NO_REQ);
        check("mid_rst_mem_addr", bridge2mem_address, '0);
        check("mid_rst_cache_msg", bridge2cache_msg, NO_REQ);
        reset = 1'b1;

        // Restarted read from word 0, L=1
        finish_txn(R_REQ, 32'h104, '0, 1, 0, 1'b0, '0);
        check("t2_line_addr", last_resp_addr, 32'h104);
        check("t2_line_data", last_resp_data,
              128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);

        // Writeback of a four-word line
        wb_line = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        start_req(WB_REQ, 32'h20, wb_line);
        finish_txn(WB_REQ, 32'h20, wb_line, 2, 0, 1'b0, '0);

        // Stale response for a foreign address while waiting on 0x104
        stale_once = 1'b1;
        start_req(R_REQ, 32'h104, '0);
        finish_txn(R_REQ, 32'h104, '0, 3, 0, 1'b0, '0);
        check("stale_consumed", stale_once, 1'b0);

        // Cache keeps requesting after the response, then chains a new line
        start_req(R_REQ, 32'h104, '0);
        finish_txn(R_REQ, 32'h104, '0, 1, 3, 1'b1, 32'h200);
        finish_txn(R_REQ, 32'h200, '0, 1, 0, 1'b0, '0);

        // Unknown message code is ignored
        start_req(4'd5, 32'h104, '0);
        repeat (3) begin
            @(negedge clock);
            check("bad_code_busy", busy, 1'b0);
            check("bad_code_mem", bridge2mem_msg, NO_REQ);
        end
        cache2bridge_msg = NO_REQ;

        // Offset bits in the request address are ignored
        start_req(R_REQ, 32'h107, '0);
        finish_txn(R_REQ, 32'h107, '0, 1, 0, 1'b0, '0);
        check("offset_line_addr", last_resp_addr, 32'h104);

        // Randomized transfers
        for (int k = 0; k < 8; k++) begin
            r_msg  = ($urandom_range(0, 1) == 1) ? R_REQ : WB_REQ;
            r_addr = $urandom_range(0, 32'h0000_3FFF);
            if (k == 3)
                r_addr = 32'h20 + $urandom_range(0, 3);
            r_data = {$urandom, $urandom, $urandom, $urandom};
            start_req(r_msg, r_addr, r_data);
            finish_txn(r_msg, r_addr, r_data, $urandom_range(1, 3), $urandom_range(0, 2),
                       1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
